// File: rtl/cbfp_pkg.sv
// Shared constants and types for the block-floating-point scaler.
//   DATA_WIDTH : signed input width per component
//   MAG_WIDTH  : width of a leading-sign-bit count
//   OUT_WIDTH  : signed output width per component
//   LANES      : complex lanes per beat
//   MAG_MAX    : largest possible count (all-sign input)
package cbfp_pkg;

  localparam int DATA_WIDTH = 25;
  localparam int MAG_WIDTH  = 5;
  localparam int OUT_WIDTH  = 12;
  localparam int LANES      = 8;

  typedef logic [MAG_WIDTH-1:0] mag_t;

  localparam mag_t MAG_MAX = mag_t'(24);

  typedef enum logic {
    IDLE,
    OUT
  } rd_state_e;

  function automatic mag_t mag_min(input mag_t a, input mag_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cbfp_min_tree.sv
// Combinational minimum of 16 magnitude counts, built as a balanced
// four-level compare tree (16 -> 8 -> 4 -> 2 -> 1).
//   mag_in      : 16 counts (8 real lanes followed by 8 imaginary lanes)
//   mag_min_out : smallest of the 16 counts
module cbfp_min_tree
  import cbfp_pkg::*;
(
  input  mag_t mag_in [16],
  output mag_t mag_min_out
);

  mag_t lvl1 [8];
  mag_t lvl2 [4];
  mag_t lvl3 [2];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl1
      assign lvl1[gi] = mag_min(mag_in[2*gi], mag_in[2*gi+1]);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl2
      assign lvl2[gi] = mag_min(lvl1[2*gi], lvl1[2*gi+1]);
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl3
      assign lvl3[gi] = mag_min(lvl2[2*gi], lvl2[2*gi+1]);
    end
  endgenerate

  assign mag_min_out = mag_min(lvl3[0], lvl3[1]);

endmodule

// File: rtl/cbfp_scale1.sv
// Block-floating-point scaler. Buffers BLK_CYC beats of LANES complex
// samples into one of two banks while tracking the minimum leading-sign
// count over the block, then replays the block left-normalized by that
// minimum and truncated to OUT_WIDTH bits.
//   clk, rstn          : clock, asynchronous active-low reset
//   din_valid          : input beat qualifier
//   din_re/din_im      : signed input samples per lane
//   mag_re/mag_im      : leading-sign counts for the same-cycle samples
//   dout_valid         : output beat qualifier
//   dout_re/dout_im    : normalized, truncated samples
//   index_out          : block minimum count, constant across a block
//   blk_last           : marks the final output beat of a block
module cbfp_scale1
  import cbfp_pkg::*;
#(
  parameter int BLK_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din_re [LANES],
  input  logic signed [DATA_WIDTH-1:0] din_im [LANES],
  input  mag_t                         mag_re [LANES],
  input  mag_t                         mag_im [LANES],
  output logic                         dout_valid,
  output logic signed [OUT_WIDTH-1:0]  dout_re [LANES],
  output logic signed [OUT_WIDTH-1:0]  dout_im [LANES],
  output mag_t                         index_out,
  output logic                         blk_last
);

  localparam int CW = $clog2(BLK_CYC);
  localparam int AW = $clog2(2*BLK_CYC);
  localparam int XW = DATA_WIDTH + OUT_WIDTH - 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] addr_t;

  localparam cnt_t CNT_LAST = cnt_t'(BLK_CYC-1);

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  rd_state_e state_q, state_d;
  cnt_t      wr_cnt_q, wr_cnt_d;
  cnt_t      rd_cnt_q, rd_cnt_d;
  logic      wr_bank_q, wr_bank_d;
  logic      rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  mag_t      run_min_q, run_min_d;
  mag_t      blk_min_q [2];
  mag_t      blk_min_d [2];
  logic      dout_valid_q, dout_valid_d;
  logic      blk_last_q, blk_last_d;
  mag_t      index_q, index_d;

  // ---------------------------------------------------------------
  // Write side: per-beat minimum and block completion
  // ---------------------------------------------------------------
  mag_t mag_all [16];
  mag_t beat_min;
  mag_t run_min_eff;
  mag_t cur_min;
  logic wr_last;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mag
      assign mag_all[gi]         = mag_re[gi];
      assign mag_all[gi + LANES] = mag_im[gi];
    end
  endgenerate

  cbfp_min_tree u_min_tree (
    .mag_in      (mag_all),
    .mag_min_out (beat_min)
  );

  assign run_min_eff = (wr_cnt_q == '0) ? MAG_MAX : run_min_q;
  assign cur_min     = mag_min(run_min_eff, beat_min);
  assign wr_last     = din_valid && (wr_cnt_q == CNT_LAST);

  // A block finishing this cycle is visible to the reader immediately,
  // so its first beat can leave on the same edge that stores its last.
  logic [1:0] full_eff;
  mag_t       min_rd;

  assign full_eff = full_q | (wr_last ? (2'b01 << wr_bank_q) : 2'b00);
  assign min_rd   = (wr_last && (wr_bank_q == rd_bank_q)) ? cur_min
                                                          : blk_min_q[rd_bank_q];

  addr_t wr_addr, rd_addr;
  assign wr_addr = wr_bank_q ? addr_t'(BLK_CYC) + addr_t'(wr_cnt_q) : addr_t'(wr_cnt_q);
  assign rd_addr = rd_bank_q ? addr_t'(BLK_CYC) + addr_t'(rd_cnt_q) : addr_t'(rd_cnt_q);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    run_min_d = run_min_q;
    blk_min_d = blk_min_q;
    if (din_valid) begin
      run_min_d = cur_min;
      if (wr_last) begin
        wr_cnt_d             = '0;
        wr_bank_d            = ~wr_bank_q;
        blk_min_d[wr_bank_q] = cur_min;
      end else begin
        wr_cnt_d = wr_cnt_q + cnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------
  logic emit;
  logic rd_last;

  // Output decode: IDLE launches beat 0 on the cycle a bank becomes
  // available, OUT streams the rest.
  always_comb begin
    emit    = 1'b0;
    rd_last = 1'b0;
    case (state_q)
      IDLE: emit = full_eff[rd_bank_q];
      OUT: begin
        emit    = 1'b1;
        rd_last = (rd_cnt_q == CNT_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (full_eff[rd_bank_q]) state_d = OUT;
      OUT:  if (rd_last) state_d = full_eff[~rd_bank_q] ? OUT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_eff;
    if (emit) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + cnt_t'(1);
    end
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_comb begin
    dout_valid_d = emit;
    blk_last_d   = rd_last;
    index_d      = emit ? min_rd : index_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      run_min_q    <= MAG_MAX;
      blk_min_q[0] <= MAG_MAX;
      blk_min_q[1] <= MAG_MAX;
      dout_valid_q <= 1'b0;
      blk_last_q   <= 1'b0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      run_min_q    <= run_min_d;
      blk_min_q    <= blk_min_d;
      dout_valid_q <= dout_valid_d;
      blk_last_q   <= blk_last_d;
      index_q      <= index_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign blk_last   = blk_last_q;
  assign index_out  = index_q;

  // ---------------------------------------------------------------
  // Per-lane buffer and normalizer
  // ---------------------------------------------------------------
  // Selecting OUT_WIDTH bits from the sample padded with OUT_WIDTH-1
  // zeros is the same as shifting left by min_rd and keeping the top
  // OUT_WIDTH bits, without building the full-width shifted word.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] mem_re [2*BLK_CYC];
      logic signed [DATA_WIDTH-1:0] mem_im [2*BLK_CYC];
      logic [XW-1:0]                ext_re, ext_im;
      logic signed [OUT_WIDTH-1:0]  re_q, re_d, im_q, im_d;

      always_ff @(posedge clk) begin
        if (din_valid) begin
          mem_re[wr_addr] <= din_re[gi];
          mem_im[wr_addr] <= din_im[gi];
        end
      end

      assign ext_re = {mem_re[rd_addr], {(OUT_WIDTH-1){1'b0}}};
      assign ext_im = {mem_im[rd_addr], {(OUT_WIDTH-1){1'b0}}};

      always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (emit) begin
          re_d = ext_re[(XW-1) - int'(min_rd) -: OUT_WIDTH];
          im_d = ext_im[(XW-1) - int'(min_rd) -: OUT_WIDTH];
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          re_q <= '0;
          im_q <= '0;
        end else begin
          re_q <= re_d;
          im_q <= im_d;
        end
      end

      assign dout_re[gi] = re_q;
      assign dout_im[gi] = im_q;
    end
  endgenerate

endmodule

// File: tb/tb_cbfp_scale1.sv
module tb_cbfp_scale1;
  import cbfp_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic din_valid = 1'b0;
  logic signed [24:0] din_re [8];
  logic signed [24:0] din_im [8];
  mag_t mag_re [8];
  mag_t mag_im [8];
  logic dout_valid;
  logic signed [11:0] dout_re [8];
  logic signed [11:0] dout_im [8];
  mag_t index_out;
  logic blk_last;

  cbfp_scale1 #(.BLK_CYC(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din_re     (din_re),
    .din_im     (din_im),
    .mag_re     (mag_re),
    .mag_im     (mag_im),
    .dout_valid (dout_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .index_out  (index_out),
    .blk_last   (blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int beat0; int lane0; int im0; int val0;
    int beat1; int lane1; int im1; int val1;
    int idx;
  } vec_t;

  typedef struct packed {
    logic [7:0][11:0] re;
    logic [7:0][11:0] im;
    logic [4:0]       idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   stamp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[7];

  // Leading-sign-bit count, standing in for the upstream detector.
  function automatic mag_t lsb_count(input logic signed [24:0] x);
    int n = 0;
    for (int i = 23; i >= 0; i--) begin
      if (x[i] == x[24]) n++;
      else break;
    end
    return mag_t'(n);
  endfunction

  function automatic logic [11:0] scale(input int val, input int sh);
    logic signed [24:0] n;
    n = 25'(val);
    n = n <<< sh;
    return n[24:13];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [7:0][11:0] a_re, a_im;
    @(posedge clk);
    #1;
    cyc++;
    if (rstn && dout_valid) begin
      stamp_q.push_back(cyc);
      for (int l = 0; l < 8; l++) begin
        a_re[l] = dout_re[l];
        a_im[l] = dout_im[l];
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        $display("beat cyc=%0d idx=%0d last=%0b re0=%0d im3=%0d", cyc, index_out, blk_last,
                 dout_re[0], dout_im[3]);
        chk("index", 128'(index_out), 128'(e.idx));
        chk("blk_last", 128'(blk_last), 128'(e.last));
        chk("data_re", 128'(a_re), 128'(e.re));
        chk("data_im", 128'(a_im), 128'(e.im));
      end
    end
  endtask

  task automatic set_beat(input int bre[8], input int bim[8]);
    for (int l = 0; l < 8; l++) begin
      din_re[l] = 25'(bre[l]);
      din_im[l] = 25'(bim[l]);
      mag_re[l] = lsb_count(25'(bre[l]));
      mag_im[l] = lsb_count(25'(bim[l]));
    end
    din_valid = 1'b1;
  endtask

  // Drives one 2-beat block (gap idle cycles after each beat) and queues
  // the expected output beats. last_cyc is the tick that accepted beat 1.
  task automatic drive_block(input vec_t v, input int gap, output int last_cyc);
    int bre[2][8];
    int bim[2][8];
    exp_t e;
    for (int b = 0; b < 2; b++)
      for (int l = 0; l < 8; l++) begin
        bre[b][l] = 0;
        bim[b][l] = 0;
      end
    if (v.im0 != 0) bim[v.beat0][v.lane0] = v.val0; else bre[v.beat0][v.lane0] = v.val0;
    if (v.im1 != 0) bim[v.beat1][v.lane1] = v.val1; else bre[v.beat1][v.lane1] = v.val1;
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < 8; l++) begin
        e.re[l] = scale(bre[b][l], v.idx);
        e.im[l] = scale(bim[b][l], v.idx);
      end
      e.idx  = 5'(v.idx);
      e.last = (b == 1);
      exp_q.push_back(e);
    end
    last_cyc = 0;
    for (int b = 0; b < 2; b++) begin
      set_beat(bre[b], bim[b]);
      tick();
      if (b == 1) last_cyc = cyc;
      if (gap > 0) begin
        din_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic chk_outputs_zero(input string name);
    logic [7:0][11:0] a_re, a_im;
    for (int l = 0; l < 8; l++) begin
      a_re[l] = dout_re[l];
      a_im[l] = dout_im[l];
    end
    chk({name, "_valid"}, 128'(dout_valid), 128'd0);
    chk({name, "_last"}, 128'(blk_last), 128'd0);
    chk({name, "_index"}, 128'(index_out), 128'd0);
    chk({name, "_data"}, 128'({a_re, a_im}), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lc;
    int zre[8];
    int zim[8];
    vec_t v;

    tbl[0] = '{0, 0, 0, 256,        1, 0, 0, 0,  15};
    tbl[1] = '{1, 3, 1, -256,       0, 0, 0, 0,  16};
    tbl[2] = '{0, 0, 0, 'h0FFFFFF,  0, 1, 0, 8192, 0};
    tbl[3] = '{0, 0, 0, 0,          1, 0, 0, 0,  24};
    tbl[4] = '{0, 5, 1, -1,         1, 7, 0, 0,  24};
    tbl[5] = '{1, 2, 0, -4096,      0, 6, 1, 100, 12};
    tbl[6] = '{0, 7, 0, -8388608,   1, 4, 1, 3,  1};

    for (int l = 0; l < 8; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
      mag_re[l] = MAG_MAX;
      mag_im[l] = MAG_MAX;
      zre[l] = 0;
      zim[l] = 0;
    end

    // Reset state
    #2 rstn = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rstn = 1'b1;
    tick();

    // Table of single blocks
    for (int t = 0; t < 7; t++) begin
      stamp_q.delete();
      drive_block(tbl[t], 0, lc);
      drain("vec");
      chk("vec_beats", 128'(stamp_q.size()), 128'd2);
      if (stamp_q.size() > 0) chk("vec_latency", 128'(stamp_q[0]), 128'(lc));
    end

    // Three back-to-back blocks, minimums 3, 10, 24
    stamp_q.delete();
    v = '{0, 2, 0, 1 << 20, 1, 0, 0, 0, 3};
    drive_block(v, 0, lc);
    v = '{1, 6, 1, 1 << 13, 0, 0, 0, 0, 10};
    drive_block(v, 0, lc);
    drive_block(tbl[3], 0, lc);
    drain("b2b");
    chk("b2b_beats", 128'(stamp_q.size()), 128'd6);
    if (stamp_q.size() == 6) chk("b2b_contig", 128'(stamp_q[5] - stamp_q[0]), 128'd5);

    // Gapped input: completes on the 2nd accepted beat, then a 2-beat burst
    stamp_q.delete();
    drive_block(tbl[2], 1, lc);
    drain("gap");
    chk("gap_beats", 128'(stamp_q.size()), 128'd2);
    if (stamp_q.size() == 2) begin
      chk("gap_latency", 128'(stamp_q[0]), 128'(lc));
      chk("gap_contig", 128'(stamp_q[1] - stamp_q[0]), 128'd1);
    end

    // Reset in the middle of a block while outputs are active
    stamp_q.delete();
    drive_block(tbl[5], 0, lc);
    zre[0] = 1 << 21;
    set_beat(zre, zim);
    tick();
    din_valid = 1'b0;
    chk("pre_rst_valid", 128'(dout_valid), 128'd1);
    #2 rstn = 1'b0;
    #1;
    chk_outputs_zero("rst_async");
    chk("rst_pending", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    stamp_q.delete();
    v = '{0, 3, 0, 8, 1, 0, 1, -16, 20};
    drive_block(v, 0, lc);
    drain("post_rst");
    chk("post_rst_beats", 128'(stamp_q.size()), 128'd2);
    if (stamp_q.size() > 0) chk("post_rst_latency", 128'(stamp_q[0]), 128'(lc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbfp_scale1.md
# cbfp_scale1

Block-floating-point scaler fed by two `cbfp_mag_detect1` instances, one per component, each giving per-lane leading-sign-bit counts for the real and imaginary data. It buffers one block of `BLK_CYC` beats of 8 complex lanes and finds the minimum magnitude index over all 16×`BLK_CYC` counts. It then replays the block, left-normalized by that minimum and truncated to `OUT_WIDTH`, with the block index attached for downstream exponent tracking.

## Interface
- `DATA_WIDTH`, 25: signed input width per component.
- `MAG_WIDTH`, 5: magnitude index width (0..24).
- `OUT_WIDTH`, 12: signed output width per component.
- `LANES`, 8: lanes per beat.
- `BLK_CYC`, 2: beats per CBFP block, at least 2.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `din_valid` in 1: input beat qualifier.
- `din_re[0:7]`, `din_im[0:7]` in `DATA_WIDTH` signed: input data.
- `mag_re[0:7]`, `mag_im[0:7]` in `MAG_WIDTH`: counts for the same-cycle `din`. These are combinational from `cbfp_mag_detect1`.
- `dout_valid` out 1: output beat qualifier.
- `dout_re[0:7]`, `dout_im[0:7]` out `OUT_WIDTH` signed: normalized data.
- `index_out` out `MAG_WIDTH`: block minimum index, held for every beat of the block.
- `blk_last` out 1: high on the final output beat of a block.

## Operation
**Write side**
- `wr_cnt` runs 0..`BLK_CYC`-1 and advances on each `din_valid`.
- Each accepted beat writes `din` into bank `wr_bank` at address `wr_cnt`.
- The running minimum is `run_min <= min(run_min_eff, min16(mag))`, where `run_min_eff` = 24 when `wr_cnt`==0.
- Idle cycles (`din_valid`=0) change nothing. Gaps are allowed anywhere in a block.
- **Block completion**, on the beat with `wr_cnt`==`BLK_CYC`-1:
  - latch the final minimum into `blk_min[wr_bank]`;
  - set `full[wr_bank]`;
  - toggle `wr_bank`;
  - wrap `wr_cnt` to 0.

**Read FSM**
- States are `IDLE` and `OUT`.
- `IDLE` → `OUT` when `full[rd_bank]`.
- In `OUT`, emit one beat per cycle from `rd_cnt`.
- At `rd_cnt`==`BLK_CYC`-1:
  - clear `full[rd_bank]` and toggle `rd_bank`;
  - if `full` of the other bank is set, or is being set in this same cycle, stay in `OUT` with no bubble; otherwise go to `IDLE`.
- There is no output backpressure. Input rate is at most one beat per cycle, so two banks never overflow. Writing into a `full` bank cannot occur.

**Arithmetic, per component**
- `norm = din <<< blk_min`, kept at `DATA_WIDTH` bits. This cannot overflow because the minimum is at most every lane's redundant-sign count.
- `dout = norm[DATA_WIDTH-1 -: OUT_WIDTH]`: truncation, no rounding, no saturation.
- `index_out = blk_min`.
- An all-zero block gives index 24 and outputs 0.
- A lone -1 gives index 24 and -2048.

## Timing
- `dout_valid` rises the cycle after the edge that accepts a block's last beat (1-cycle latency from the last beat).
- With continuous input, the first output comes `BLK_CYC` cycles after the first input.
- Outputs are registered. `dout`, `index_out` and `blk_last` are valid only with `dout_valid`.
- **Reset values:**
  - `dout_valid`=0, `blk_last`=0, all `dout`=0, `index_out`=0.
  - `wr_cnt`, `rd_cnt`, `wr_bank`, `rd_bank` and `full` cleared.
  - `run_min`=24.
  - Buffer RAM contents are not reset.
- **Reset mid-operation** discards the partial block and any pending full banks. The first beat after `rstn` rises starts a new block.
- **Simultaneous completion and last read beat**, with continuous `din_valid`: the output stream stays continuous, and `index_out` changes on the first beat of the new block.

## Structure
- `cbfp_pkg` holds:
  - localparams `DATA_WIDTH`, `MAG_WIDTH`, `OUT_WIDTH`, `LANES`;
  - `MAG_MAX`=24;
  - `typedef logic [MAG_WIDTH-1:0] mag_t`;
  - `typedef enum logic {IDLE, OUT} rd_state_e`.
- Sub-module `cbfp_min_tree`: combinational 16-input `mag_t` minimum as a balanced 4-level compare tree, used on the write side.
- Buffer: 2×`BLK_CYC` entries of 16×`DATA_WIDTH`, as registers or distributed RAM.

## Test plan
1. Block with only `din_re[0]`=256 on beat 0 (mag 15; every other mag 24) → `index_out`=15, `dout_re[0]`=1024 on beat 0, all other outputs 0, `blk_last` on beat 1.
2. Single nonzero `din_im[3]`=-256 on beat 1 (mag 16) → `index_out`=16, `dout_im[3]`=-2048, `dout_valid` 1 cycle after that beat.
3. Beat 0 lane 0 = 0x0FFFFFF (mag 0), lane 1 = 8192 → `index_out`=0, `dout_re[0]`=2047, `dout_re[1]`=1.
4. Three back-to-back blocks, continuous valid, with minimums 3, 10, 24 → `dout_valid` continuously high for 6 beats, `index_out` sequence 3,3,10,10,24,24, `blk_last` on beats 2, 4, 6.
5. `din_valid` toggling 1,0,1,0 → the block completes on the 2nd accepted beat, followed by a 2-beat contiguous output burst.
6. `rstn` low after beat 0 of a block → all outputs 0 immediately. The next two beats after release form a clean block whose index is independent of the pre-reset data.
